// File: rtl/tick_stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM states, BCD time
// layout, digit limits and the active-low seven-segment patterns.
package tick_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] min_hi;
    logic [3:0] min_lo;
    logic [3:0] sec_hi;
    logic [3:0] sec_lo;
  } bcd_time_t;

  localparam logic [3:0] BCD_LO_MAX = 4'd9;
  localparam logic [3:0] BCD_HI_MAX = 4'd5;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // {g,f,e,d,c,b,a}, active-low; entry n is the glyph for digit n
  localparam logic [9:0][6:0] SEG_PATTERNS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [3:0] bcd_pick(input bcd_time_t t, input logic [1:0] sel);
    logic [3:0] d;
    case (sel)
      2'd0:    d = t.sec_lo;
      2'd1:    d = t.sec_hi;
      2'd2:    d = t.min_lo;
      default: d = t.min_hi;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_stopwatch_if.sv
// Control/display bundle of the stopwatch. TICK_STOPWATCH_LAP_EN adds the lap
// pulse; master drives the pulses, slave is the stopwatch itself.
interface tick_stopwatch_if;

  logic        tick;
  logic        start_stop;
  logic        clear;
`ifdef TICK_STOPWATCH_LAP_EN
  logic        lap;
`endif
  logic [15:0] digits;
  logic        running;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;

`ifdef TICK_STOPWATCH_LAP_EN
  modport master (
    output tick, start_stop, clear, lap,
    input  digits, running, wrap, an, seg
  );
  modport slave (
    input  tick, start_stop, clear, lap,
    output digits, running, wrap, an, seg
  );
`else
  modport master (
    output tick, start_stop, clear,
    input  digits, running, wrap, an, seg
  );
  modport slave (
    input  tick, start_stop, clear,
    output digits, running, wrap, an, seg
  );
`endif

endinterface

// File: rtl/tick_stopwatch_sevenseg_decoder.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes blank the digit.
module sevenseg_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  import tick_stopwatch_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= BCD_LO_MAX) seg = SEG_PATTERNS[bcd];
  end

endmodule

// File: rtl/tick_stopwatch.sv
// MM:SS stopwatch with IDLE/RUN/PAUSE control and 4-digit multiplexed display.
// Build option TICK_STOPWATCH_LAP_EN adds a lap-freeze of the displayed value.
//
//   state | meaning
//   IDLE  | time held at zero, waiting for start
//   RUN   | ticks advance the count
//   PAUSE | count held; start resumes, clear zeroes and returns to IDLE
module tick_stopwatch #(
  parameter int unsigned REFRESH_DIV = 24000
) (
  input logic             CLK,
  input logic             reset,
  tick_stopwatch_if.slave bus
);
  import tick_stopwatch_pkg::*;

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t     state_q, state_d;
  logic       count_en, clr_en;
  bcd_time_t  cnt_q, cnt_d;
  logic       wrap_d, wrap_q;
  logic       running_q;
  bcd_time_t  disp;

  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       sel_q;
  logic [3:0]       digit_mux;
  logic [6:0]       seg_dec;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    clr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_stop) state_d = RUN;
      end
      RUN: begin
        count_en = bus.tick;
        if (bus.start_stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (bus.clear) begin
          state_d = IDLE;
          clr_en  = 1'b1;
        end else if (bus.start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ripple carry through the four digits; only a full 59:59 rollover flags wrap
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_en) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d.sec_lo = cnt_q.sec_lo + 4'd1;
      if (cnt_q.sec_lo == BCD_LO_MAX) begin
        cnt_d.sec_lo = '0;
        cnt_d.sec_hi = cnt_q.sec_hi + 4'd1;
        if (cnt_q.sec_hi == BCD_HI_MAX) begin
          cnt_d.sec_hi = '0;
          cnt_d.min_lo = cnt_q.min_lo + 4'd1;
          if (cnt_q.min_lo == BCD_LO_MAX) begin
            cnt_d.min_lo = '0;
            cnt_d.min_hi = cnt_q.min_hi + 4'd1;
            if (cnt_q.min_hi == BCD_HI_MAX) begin
              cnt_d.min_hi = '0;
              wrap_d       = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == RUN);
    end
  end

`ifdef TICK_STOPWATCH_LAP_EN
  logic      frozen_q;
  bcd_time_t snap_q;

  // the snapshot is the count as it stood when the freezing lap arrived
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else if (clr_en) begin
      frozen_q <= 1'b0;
    end else if ((state_q == RUN) && bus.lap) begin
      frozen_q <= ~frozen_q;
      if (!frozen_q) snap_q <= cnt_q;
    end
  end

  assign disp = frozen_q ? snap_q : cnt_q;
`else
  assign disp = cnt_q;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      sel_q     <= 2'd0;
    end else if (refresh_q == CNT_LAST) begin
      refresh_q <= '0;
      sel_q     <= sel_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  assign digit_mux = bcd_pick(disp, sel_q);

  sevenseg_decoder u_dec (
    .bcd (digit_mux),
    .seg (seg_dec)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << sel_q);
      seg_q <= seg_dec;
    end
  end

  assign bus.digits  = disp;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: directed pulses against a seconds-based model,
// checked every cycle, plus literal spot checks at the interesting points.
module tb_tick_stopwatch;

  localparam int DIV = 4;

  logic CLK   = 1'b0;
  logic reset = 1'b0;

  tick_stopwatch_if bus ();

  tick_stopwatch #(.REFRESH_DIV(DIV)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // model: 0 = idle, 1 = run, 2 = pause; time kept as plain seconds
  int          m_state;
  int          m_secs;
  int          m_edges;
  bit          m_running;
  bit          m_wrap;
  bit          m_frozen;
  logic [15:0] m_snap;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  function automatic logic [15:0] to_bcd(input int s);
    int mins, secs;
    mins = s / 60;
    secs = s % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] shown();
    return m_frozen ? m_snap : to_bcd(m_secs);
  endfunction

  task automatic model_reset();
    m_state   = 0;
    m_secs    = 0;
    m_edges   = 0;
    m_running = 1'b0;
    m_wrap    = 1'b0;
    m_frozen  = 1'b0;
    m_snap    = '0;
    m_an      = 4'b1111;
    m_seg     = 7'b1111111;
  endtask

  task automatic model_step();
    logic [15:0] pd;
    int          ps;
    int          pre;
    bit          lap_in;
    pd     = shown();
    ps     = (m_edges / DIV) % 4;
    pre    = m_state;
    lap_in = 1'b0;
`ifdef TICK_STOPWATCH_LAP_EN
    lap_in = bus.lap;
`endif
    if (pre == 1 && lap_in) begin
      if (!m_frozen) m_snap = to_bcd(m_secs);
      m_frozen = !m_frozen;
    end
    m_wrap = 1'b0;
    if (pre == 1 && bus.tick) begin
      m_secs = m_secs + 1;
      if (m_secs == 3600) begin
        m_secs = 0;
        m_wrap = 1'b1;
      end
    end
    case (pre)
      0: if (bus.start_stop) m_state = 1;
      1: if (bus.start_stop) m_state = 2;
      default: begin
        if (bus.clear) begin
          m_state  = 0;
          m_secs   = 0;
          m_frozen = 1'b0;
        end else if (bus.start_stop) begin
          m_state = 1;
        end
      end
    endcase
    m_running = (m_state == 1);
    m_an      = ~(4'b0001 << ps);
    m_seg     = seg_of(pd[ps*4 +: 4]);
    m_edges   = m_edges + 1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      check("digits",  bus.digits,          shown());
      check("running", 16'(bus.running),    16'(m_running));
      check("wrap",    16'(bus.wrap),       16'(m_wrap));
      check("an",      16'(bus.an),         16'(m_an));
      check("seg",     16'(bus.seg),        16'(m_seg));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still going at %0t, expected end", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic t, input logic s, input logic c, input logic l);
    bus.tick       = t;
    bus.start_stop = s;
    bus.clear      = c;
`ifdef TICK_STOPWATCH_LAP_EN
    bus.lap        = l;
`endif
    @(posedge CLK);
    #1;
    bus.tick       = 1'b0;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
`ifdef TICK_STOPWATCH_LAP_EN
    bus.lap        = 1'b0;
`endif
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.tick       = 1'b0;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
`ifdef TICK_STOPWATCH_LAP_EN
    bus.lap        = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("rst_digits",  bus.digits,       16'h0000);
    check("rst_an",      16'(bus.an),      16'h000F);
    check("rst_seg",     16'(bus.seg),     16'h007F);
    check("rst_running", 16'(bus.running), 16'h0000);
    reset = 1'b1;

    // display scan with the count at zero
    @(posedge CLK); #1;
    check("scan_an0",  16'(bus.an),  16'(4'b1110));
    check("scan_seg0", 16'(bus.seg), 16'(7'b1000000));
    repeat (4) begin @(posedge CLK); #1; end
    check("scan_an1", 16'(bus.an), 16'(4'b1101));
    repeat (4) begin @(posedge CLK); #1; end
    check("scan_an2", 16'(bus.an), 16'(4'b1011));
    repeat (4) begin @(posedge CLK); #1; end
    check("scan_an3", 16'(bus.an), 16'(4'b0111));
    repeat (87) begin @(posedge CLK); #1; end

    // run 75 s then pause, ticks ignored while paused
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(75);
    check("run75_digits",  bus.digits,       16'h0115);
    check("run75_running", 16'(bus.running), 16'h0001);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(5);
    check("pause_digits",  bus.digits,       16'h0115);
    check("pause_running", 16'(bus.running), 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("pause_clear", bus.digits, 16'h0000);

    // clear wins over start_stop in PAUSE
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(42);
    check("run42_digits", bus.digits, 16'h0042);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_ss_digits",  bus.digits,       16'h0000);
    check("clr_ss_running", 16'(bus.running), 16'h0000);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // clear ignored in RUN; tick with the leaving start_stop still counts
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("run_clear_digits",  bus.digits,       16'h0005);
    check("run_clear_running", 16'(bus.running), 16'h0001);
    tick_n(4);
    check("run9_digits", bus.digits, 16'h0009);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("tick_ss_digits",  bus.digits,       16'h0010);
    check("tick_ss_running", 16'(bus.running), 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(3);
    check("paused_hold", bus.digits, 16'h0010);

    // entering RUN together with a tick does not count it
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("enter_tick_digits", bus.digits, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // full-range rollover
    tick_n(3599);
    check("pre_wrap_digits", bus.digits,    16'h5959);
    check("pre_wrap_wrap",   16'(bus.wrap), 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_digits", bus.digits,    16'h0000);
    check("wrap_pulse",  16'(bus.wrap), 16'h0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_end", 16'(bus.wrap), 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-tick at 12:34
    tick_n(754);
    check("at_1234", bus.digits, 16'h1234);
    bus.tick = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_digits",  bus.digits,       16'h0000);
    check("async_running", 16'(bus.running), 16'h0000);
    check("async_wrap",    16'(bus.wrap),    16'h0000);
    check("async_an",      16'(bus.an),      16'h000F);
    check("async_seg",     16'(bus.seg),     16'h007F);
    bus.tick = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef TICK_STOPWATCH_LAP_EN
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(10);
    check("lap_before", bus.digits, 16'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    tick_n(5);
    check("lap_frozen", bus.digits, 16'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_release", bus.digits, 16'h0015);
`endif

    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
Name: tick_stopwatch

Overview:
- MM:SS stopwatch driven by the once-per-second single-cycle tick from the system clock-divider stage; the tick connects directly to this block's `tick` input.
- Holds four BCD digits and runs an IDLE/RUN/PAUSE control FSM from debounced button pulses.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the divider and the board display pins.

Parameters:
- REFRESH_DIV, 24000, clock cycles each digit is shown during multiplexing (1 kHz per digit at 24 MHz); legal range 2..2^20.

Ports:
- CLK  input  1  system clock (24 MHz)
- reset  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle advance pulse; the divider guarantees at least 2 idle cycles between pulses
- start_stop  input  1  one-cycle debounced pulse; toggles run/pause
- clear  input  1  one-cycle debounced pulse; zeroes time when not running
- digits  output  16  BCD {min_hi, min_lo, sec_hi, sec_lo}, registered
- running  output  1  high in RUN
- wrap  output  1  one-cycle pulse when the count rolls 59:59 -> 00:00
- an  output  4  digit enables, active-low; bit0 = sec_lo
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, digits=16'h0000, running=0, wrap=0.
  - Display: an=4'b1111, seg=7'b1111111, refresh counter=0, sel=0.
- FSM states: IDLE, RUN, PAUSE. Transitions are evaluated on the registered state.
  - IDLE: start_stop -> RUN. clear -> IDLE (no change).
  - RUN: start_stop -> PAUSE. clear is ignored.
  - PAUSE: start_stop -> RUN. clear -> IDLE with digits zeroed.
  - PAUSE with clear and start_stop in the same cycle: clear wins -> IDLE, zeroed.
- running is registered and equals (state==RUN); it changes on the edge after the start_stop pulse.
- Counting happens only when the pre-edge state is RUN and tick=1. Consequences:
  - A tick coinciding with the start_stop that leaves RUN is counted.
  - A tick coinciding with the start_stop that enters RUN is not counted.
- Digit arithmetic (ripple carry, all updated on the same edge as the tick):
  - sec_lo 0..9; at 9 -> 0 and carry.
  - sec_hi 0..5; at 5 -> 0 and carry.
  - min_lo 0..9; at 9 -> 0 and carry.
  - min_hi 0..5; at 5 -> 0 and assert wrap.
  - wrap is high for exactly the cycle after the edge where 59:59 -> 00:00.
- Digits never hold a non-BCD value. Latency tick -> digits is 1 cycle.
- Display multiplexing:
  - Refresh counter counts 0..REFRESH_DIV-1 continuously, independent of FSM state.
  - At terminal count, sel (2 bits) increments modulo 4.
  - an and seg are both registered every cycle from the current sel and digits: an = ~(1<<sel), seg = decode(digit[sel]). They change on the same edge, with 1-cycle latency from digits/sel.
  - Decode for 0..9 uses the standard patterns; 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000. Any other value -> 7'b1111111 (unreachable in normal operation).
- Reset asserted mid-count: immediate return to the reset values listed above; no wrap pulse is emitted.

Optional Feature:
- Macro: TICK_STOPWATCH_LAP_EN.
- When defined:
  - Extra input port lap (1-bit pulse). In RUN, lap toggles a frozen flag.
  - While frozen, the display (an/seg and digits output) shows a 16-bit snapshot captured on the lap edge, while internal counting continues.
  - A second lap pulse unfreezes the display.
  - Leaving RUN to PAUSE keeps the frozen state; clear or reset unfreezes.
- When not defined: no lap port; the display always shows the live count.

Decomposition:
- Package tick_stopwatch_pkg contains:
  - state typedef {IDLE, RUN, PAUSE}
  - BCD limit constants (9, 5)
  - SEG_BLANK = 7'b1111111
  - the 10-entry seven-segment pattern constant
- Sub-module sevenseg_decoder: combinational 4-bit BCD -> 7-bit active-low segments. It is instantiated once, fed by the digit mux, with its output registered in tick_stopwatch.

Test Plan:
- Reset then idle 100 cycles with REFRESH_DIV=4:
  - an cycles 1110 -> 1101 -> 1011 -> 0111, each held for 4 cycles.
  - seg=7'b1000000 throughout; digits=0000; running=0.
- start_stop, then 75 ticks: digits=16'h0115 (01:15), running=1; then start_stop, then 5 ticks -> digits unchanged, running=0.
- Preload 3599 ticks in RUN (digits=16'h5959), then 1 tick:
  - digits=16'h0000 the next cycle.
  - wrap high for exactly 1 cycle.
- In PAUSE at 16'h0042, clear and start_stop in the same cycle -> state IDLE, digits=0000, running=0.
- In RUN, clear pulse -> ignored, digits keep counting. In RUN, tick and start_stop in the same cycle at 16'h0009 -> digits=16'h0010, then PAUSE.
- Reset asserted asynchronously mid-tick at 16'h1234 -> outputs go to reset values without waiting for a CLK edge.
- With TICK_STOPWATCH_LAP_EN: lap at 00:10, then 5 ticks -> display shows 0010 while internal count is 0015; second lap -> display shows 0015.
